// File: rtl/alu_pkg.sv
// Shared opcode values, widths and a small padding helper for the ALU slice.
package alu_pkg;

  localparam int OPW  = 4;
  localparam int RESW = 8;

  localparam logic [OPW-1:0] OP_ADD  = 4'h0;
  localparam logic [OPW-1:0] OP_SUB  = 4'h1;
  localparam logic [OPW-1:0] OP_MUL  = 4'h2;
  localparam logic [OPW-1:0] OP_DIV  = 4'h3;
  localparam logic [OPW-1:0] OP_MOD  = 4'h4;
  localparam logic [OPW-1:0] OP_AND  = 4'h5;
  localparam logic [OPW-1:0] OP_OR   = 4'h6;
  localparam logic [OPW-1:0] OP_XOR  = 4'h7;
  localparam logic [OPW-1:0] OP_NAND = 4'h8;
  localparam logic [OPW-1:0] OP_NOR  = 4'h9;
  localparam logic [OPW-1:0] OP_XNOR = 4'hA;
  localparam logic [OPW-1:0] OP_NOT  = 4'hB;
  localparam logic [OPW-1:0] OP_SHL  = 4'hC;
  localparam logic [OPW-1:0] OP_SHR  = 4'hD;
  localparam logic [OPW-1:0] OP_ROL  = 4'hE;
  localparam logic [OPW-1:0] OP_CMP  = 4'hF;

  // Zero-extend a 4-bit value into the 8-bit result width.
  function automatic logic [RESW-1:0] pad_res(input logic [OPW-1:0] v);
    return {{(RESW-OPW){1'b0}}, v};
  endfunction

endpackage

// File: rtl/alu_if.sv
// Operand/opcode/result bundle between an ALU user and the ALU.
interface alu_if;
  import alu_pkg::*;

  logic [OPW-1:0]  a;
  logic [OPW-1:0]  b;
  logic [OPW-1:0]  sel;
  logic [RESW-1:0] out;

  modport master (output a, output b, output sel, input out);
  modport slave  (input a, input b, input sel, output out);
endinterface

// File: rtl/alu_core.sv
// Combinational ALU function: (a, b, sel) -> next 8-bit result.
module alu_core
  import alu_pkg::*;
(
  input  logic [OPW-1:0]  i_a,
  input  logic [OPW-1:0]  i_b,
  input  logic [OPW-1:0]  i_sel,
  output logic [RESW-1:0] o_result
);

  logic [RESW-1:0] w_a8;
  logic [RESW-1:0] w_b8;
  logic            w_b_zero;

  assign w_a8     = pad_res(i_a);
  assign w_b8     = pad_res(i_b);
  assign w_b_zero = (i_b == '0);

  // Opcode decode; arithmetic is done at full result width so carries are kept.
  always_comb begin
    o_result = '0;
    case (i_sel)
      OP_ADD:  o_result = w_a8 + w_b8;
      OP_SUB:  o_result = w_a8 - w_b8;
      OP_MUL:  o_result = w_a8 * w_b8;
      OP_DIV:  o_result = w_b_zero ? 8'hFF : (w_a8 / w_b8);
      OP_MOD:  o_result = w_b_zero ? w_a8  : (w_a8 % w_b8);
      OP_AND:  o_result = pad_res(i_a & i_b);
      OP_OR:   o_result = pad_res(i_a | i_b);
      OP_XOR:  o_result = pad_res(i_a ^ i_b);
      OP_NAND: o_result = pad_res(~(i_a & i_b));
      OP_NOR:  o_result = pad_res(~(i_a | i_b));
      OP_XNOR: o_result = pad_res(~(i_a ^ i_b));
      OP_NOT:  o_result = pad_res(~i_a);
      OP_SHL:  o_result = {3'b000, i_a, 1'b0};
      OP_SHR:  o_result = {5'b00000, i_a[3:1]};
      OP_ROL:  o_result = pad_res({i_a[2:0], i_a[3]});
      OP_CMP:  o_result = {5'b00000, (i_a > i_b), (i_a == i_b), (i_a < i_b)};
      // Only reachable with X/Z on sel; keeps the output from going unknown.
      default: o_result = '0;
    endcase
  end

endmodule

// File: rtl/alu.sv
// 4-bit, 16-function ALU with a single registered 8-bit result stage.
module alu
  import alu_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  alu_if.slave   bus
);

  logic [RESW-1:0] w_next;
  logic [RESW-1:0] r_out;

  alu_core u_core (
    .i_a      (bus.a),
    .i_b      (bus.b),
    .i_sel    (bus.sel),
    .o_result (w_next)
  );

  // Result register; reset clears it immediately, without waiting for a clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out <= '0;
    end else begin
      r_out <= w_next;
    end
  end

  assign bus.out = r_out;

endmodule

// File: tb/tb_alu.sv
// Directed-vector bench for the registered ALU.
module tb_alu;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  alu_if u_if ();

  alu u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (u_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h expected %02h", tag, got, exp);
    end else begin
      $display("ok   %s: out=%02h", tag, got);
    end
  endtask

  // Drive one operation at the falling edge, check it just after the next rising edge.
  task automatic apply(input string tag, input logic [3:0] a, input logic [3:0] b,
                       input logic [3:0] sel, input logic [7:0] exp);
    @(negedge clk);
    u_if.a   = a;
    u_if.b   = b;
    u_if.sel = sel;
    @(posedge clk);
    #1;
    check(tag, u_if.out, exp);
  endtask

  logic [7:0] sweep_exp [16];

  initial begin
    n_tests = 0;
    n_fail  = 0;
    sweep_exp = '{8'h0F, 8'h05, 8'h32, 8'h02, 8'h00, 8'h00, 8'h0F, 8'h0F,
                  8'h0F, 8'h00, 8'h00, 8'h05, 8'h14, 8'h05, 8'h05, 8'h04};

    // Asynchronous reset with non-zero inputs, before any clock edge.
    rst_n    = 1'b1;
    u_if.a   = 4'hA;
    u_if.b   = 4'h5;
    u_if.sel = 4'h2;
    #2 rst_n = 1'b0;
    #1 check("reset_async", u_if.out, 8'h00);
    @(posedge clk); #1 check("reset_hold1", u_if.out, 8'h00);
    @(posedge clk); #1 check("reset_hold2", u_if.out, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("reset_release", u_if.out, 8'h00);
    @(posedge clk); #1 check("first_after_rst", u_if.out, 8'h32);

    // Opcode sweep a=A, b=5.
    for (int i = 0; i < 16; i++) begin
      apply($sformatf("sweep_sel%0h", i), 4'hA, 4'h5, 4'(i), sweep_exp[i]);
    end

    // Arithmetic edges.
    apply("add_f_f", 4'hF, 4'hF, 4'h0, 8'h1E);
    apply("mul_f_f", 4'hF, 4'hF, 4'h2, 8'hE1);
    apply("sub_3_5", 4'h3, 4'h5, 4'h1, 8'hFE);
    apply("sub_0_f", 4'h0, 4'hF, 4'h1, 8'hF1);

    // Divide by zero and recovery.
    apply("div_9_0", 4'h9, 4'h0, 4'h3, 8'hFF);
    apply("mod_9_0", 4'h9, 4'h0, 4'h4, 8'h09);
    apply("div_9_2", 4'h9, 4'h2, 4'h3, 8'h04);
    apply("mod_9_2", 4'h9, 4'h2, 4'h4, 8'h01);

    // Compare.
    apply("cmp_7_7", 4'h7, 4'h7, 4'hF, 8'h02);
    apply("cmp_2_9", 4'h2, 4'h9, 4'hF, 8'h01);
    apply("cmp_9_2", 4'h9, 4'h2, 4'hF, 8'h04);

    // Shift/rotate with top bit set.
    apply("shl_9", 4'h9, 4'h0, 4'hC, 8'h12);
    apply("rol_9", 4'h9, 4'h0, 4'hE, 8'h03);

    // Mid-run reset pulse between edges.
    apply("pre_midrst_mul", 4'hA, 4'h5, 4'h2, 8'h32);
    #2 rst_n = 1'b0;
    #1 check("midrst_async", u_if.out, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("midrst_release", u_if.out, 8'h00);
    @(posedge clk); #1 check("midrst_first", u_if.out, 8'h32);
    apply("post_midrst_add", 4'hA, 4'h5, 4'h0, 8'h0F);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
